// File: rtl/rr_pkg.sv
// rr_pkg: shared types and helpers for the on-the-fly converter.
// Digit-width derivation, MSD field extract, FSM state type.
package rr_pkg;

  // Widest packed word the extract helper accepts.
  localparam int RR_VEC_W = 512;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } rr_state_e;

  // Bits of magnitude per digit: log2 of the radix.
  function automatic int rr_k(input int radix);
    return $clog2(radix);
  endfunction

  // Bits per signed digit: magnitude plus sign.
  function automatic int rr_d(input int radix);
    return $clog2(radix) + 1;
  endfunction

  // Returns digit idx (dw bits each) of vec, zero-padded to 8 bits.
  function automatic logic [7:0] rr_dig(
    input logic [RR_VEC_W-1:0] vec,
    input int                  idx,
    input int                  dw
  );
    logic [RR_VEC_W-1:0] s;
    logic [7:0]          m;
    s = vec >> (idx * dw);
    m = (8'd1 << dw) - 8'd1;
    return s[7:0] & m;
  endfunction

endpackage

// File: rtl/rr_otf_step.sv
// rr_otf_step: one MSD-first on-the-fly conversion step (combinational).
// Ports: q/qm current registers, d signed digit; q_nxt/qm_nxt updated.
module rr_otf_step #(
  parameter int K  = 2,
  parameter int QW = 19
) (
  input  logic [QW-1:0] q,
  input  logic [QW-1:0] qm,
  input  logic [K:0]    d,
  output logic [QW-1:0] q_nxt,
  output logic [QW-1:0] qm_nxt
);

  logic [QW-1:0] dx;
  logic [QW-1:0] rx;
  logic [QW-1:0] q_add;
  logic [QW-1:0] qm_add;
  logic          d_neg;
  logic          d_pos;

  // Appends are done as true additions so that the out-of-range
  // digit -RADIX still follows the arithmetic update rule.
  always_comb begin
    dx     = {{(QW-K-1){d[K]}}, d};
    rx     = QW'(1) << K;
    d_neg  = d[K];
    d_pos  = !d[K] && (d != '0);
    q_add  = d_neg ? rx + dx : dx;
    qm_add = d_pos ? dx - QW'(1)
                   : rx + dx - QW'(1);
    q_nxt  = ((d_neg ? qm : q) << K) + q_add;
    qm_nxt = ((d_pos ? q : qm) << K) + qm_add;
  end

endmodule

// File: rtl/rr_otf_conv.sv
// rr_otf_conv: digit-serial OTF converter, redundant word in, 2's comp out.
// Ports: clk, rst, in_valid/in_ready/p_in, out_valid/out_ready/q_out;
// err_out (bad -RADIX digit seen) only when RR_OTF_DIGCHK_EN is defined.
module rr_otf_conv
  import rr_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int RADIX = 4,
  localparam int K     = rr_k(RADIX),
  localparam int D     = rr_d(RADIX),
  localparam int NDIG  = 2 * WIDTH + 1,
  localparam int QW    = K * NDIG + 1,
  localparam int CW    = $clog2(NDIG + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [D*NDIG-1:0] p_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [QW-1:0]   q_out
`ifdef RR_OTF_DIGCHK_EN
  ,
  output logic            err_out
`endif
);

  rr_state_e         state_q, state_d;
  logic [D*NDIG-1:0] sreg_q, sreg_d;
  logic [QW-1:0]     q_q, q_d;
  logic [QW-1:0]     qm_q, qm_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [D-1:0]      msd;
  logic [QW-1:0]     q_nxt;
  logic [QW-1:0]     qm_nxt;

`ifdef RR_OTF_DIGCHK_EN
  logic err_q, err_d;
  logic msd_bad;
`endif

  assign msd = D'(rr_dig(RR_VEC_W'(sreg_q), NDIG - 1, D));

  rr_otf_step #(
    .K  (K),
    .QW (QW)
  ) u_step (
    .q      (q_q),
    .qm     (qm_q),
    .d      (msd),
    .q_nxt  (q_nxt),
    .qm_nxt (qm_nxt)
  );

`ifdef RR_OTF_DIGCHK_EN
  // -RADIX is sign bit set with all magnitude bits clear.
  assign msd_bad = (msd == {1'b1, {K{1'b0}}});
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
`ifdef RR_OTF_DIGCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
`ifdef RR_OTF_DIGCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
`ifdef RR_OTF_DIGCHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = p_in;
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
          state_d = CONV;
`ifdef RR_OTF_DIGCHK_EN
          err_d   = 1'b0;
`endif
        end
      end
      CONV: begin
        sreg_d = sreg_q << D;
        q_d    = q_nxt;
        qm_d   = qm_nxt;
        cnt_d  = cnt_q + CW'(1);
`ifdef RR_OTF_DIGCHK_EN
        if (msd_bad) err_d = 1'b1;
`endif
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q_out     = q_q;

`ifdef RR_OTF_DIGCHK_EN
  assign err_out = err_q && (state_q == DONE);
`endif

endmodule

// File: tb/tb_rr_otf_conv.sv
// tb_rr_otf_conv: directed bench for rr_otf_conv, WIDTH=4 RADIX=4.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_rr_otf_conv;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] p_in;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] q_out;
`ifdef RR_OTF_DIGCHK_EN
  logic        err_out;
`endif

  int errors = 0;
  int checks = 0;

  rr_otf_conv #(
    .WIDTH (4),
    .RADIX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p_in      (p_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_out     (q_out)
`ifdef RR_OTF_DIGCHK_EN
    ,
    .err_out   (err_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Offer a word; returns on the falling edge after acceptance.
  task automatic start(input logic [26:0] p, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    p_in     = p;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
  endtask

  // Counts edges from acceptance to out_valid (bounded).
  task automatic wait_done(input logic [18:0] exp,
                           input string tag);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd9);
    chk({tag, "_q"}, 32'(q_out), 32'(exp));
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov0"}, 32'(out_valid), 32'd0);
    chk({tag, "_ir1"}, 32'(in_ready), 32'd1);
  endtask

  task automatic convert(input logic [26:0] p,
                         input logic [18:0] exp,
                         input string tag);
    start(p, tag);
    wait_done(exp, tag);
    take(tag);
  endtask

  // Encodings: +1=001 +2=010 +3=011 -1=111 -3=101
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    p_in      = '0;
    repeat (2) @(negedge clk);
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q_out), 32'd0);
    rst = 1'b0;

    convert(27'd0, 19'd0, "zero");
    convert({3'b001, 24'd0}, 19'd65536, "msd1");
    convert({3'b001, {8{3'b101}}}, 19'd1, "qm_path");
    convert({9{3'b101}}, 19'h40001, "all_m3");
    convert({9{3'b011}}, 19'h3FFFF, "all_p3");
    convert({24'd0, 3'b111}, 19'h7FFFF, "m1");
    convert({21'd0, 3'b010, 3'b101}, 19'd5, "mix");

    // Hold DONE with a second word pending.
    start({9{3'b011}}, "hold");
    wait_done(19'h3FFFF, "hold");
    in_valid = 1'b1;
    p_in     = {3'b001, 24'd0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_ov", 32'(out_valid), 32'd1);
      chk("hold_q", 32'(q_out), 32'h3FFFF);
      chk("hold_ir", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_ir", 32'(in_ready), 32'd1);
    chk("hs_ov", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("acc2_ir", 32'(in_ready), 32'd0);
    wait_done(19'd65536, "w2");
    take("w2");

    // Abort mid-conversion at cnt=4.
    start({9{3'b011}}, "abort");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ov", 32'(out_valid), 32'd0);
    chk("abort_ir", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    convert({21'd0, 3'b010, 3'b101}, 19'd5, "post");

`ifdef RR_OTF_DIGCHK_EN
    start({15'd0, 3'b100, 9'd0}, "bad");
    wait_done(19'h7FF00, "bad");
    chk("bad_err", 32'(err_out), 32'd1);
    take("bad");
    start(27'd0, "good");
    wait_done(19'd0, "good");
    chk("good_err", 32'(err_out), 32'd0);
    take("good");
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_otf_conv.md
Name: rr_otf_conv

Overview:
- Digit-serial on-the-fly converter (OTFC) directly downstream of the parallel radix-r online multiplier.
- Accepts one redundant signed-digit product word (2*WIDTH+1 digits, D bits per digit) through a valid/ready handshake.
- Converts it MSD-first, one digit per cycle, using Q/QM on-the-fly registers.
- Presents the conventional two's-complement result through a valid/ready handshake. No carry-propagate adder is needed.

Parameters:
- WIDTH, 4: multiplier operand digits. Number of input digits NDIG = 2*WIDTH+1.
- RADIX, 4: digit radix. Must be a power of two and >= 4.
- Derived localparams: K = $clog2(RADIX); D = K+1; NDIG = 2*WIDTH+1; QW = K*NDIG+1; CW = $clog2(NDIG+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  p_in holds a valid product word.
- in_ready  out  1  converter can accept a word.
- p_in  in  D*NDIG  redundant product. Digit i = p_in[D*i +: D], a two's-complement value in [-(RADIX-1), RADIX-1]. Digit NDIG-1 is the MSD. Word value V = sum d_i*RADIX^i.
- out_valid  out  1  q_out holds a converted result.
- out_ready  in  1  consumer takes the result.
- q_out  out  QW  V as a signed two's-complement number.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, in_ready=1, out_valid=0, q_out=0.
  - Q=0, QM=all-ones, digit counter=0, shift register=0.
  - Reset asserted mid-conversion aborts the word; no partial result is ever flagged valid.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load p_in into the shift register, Q<=0, QM<=-1, cnt<=0, go to CONV.
- CONV:
  - in_ready=0, out_valid=0.
  - Each cycle take the MSD d from the shift register and shift it left by D.
  - If d>=0: Q<=Q*r+d. Otherwise Q<=QM*r+(r+d).
  - If d>0: QM<=Q*r+(d-1). Otherwise QM<=QM*r+(r-1+d).
  - All arithmetic is modulo 2^QW. Multiply-by-r is a left shift by K; the append is a K-bit concatenation.
  - cnt increments each cycle. After the cycle with cnt==NDIG-1, go to DONE.
- DONE:
  - out_valid=1; q_out=Q is registered and stable.
  - On out_ready, go to IDLE with out_valid<=0.
  - out_ready low holds q_out and out_valid indefinitely.
- Latency: acceptance edge t gives out_valid=1 after edge t+NDIG. Throughput is one word per NDIG+2 cycles minimum.
- in_ready and out_valid are never both 1. in_valid is ignored outside IDLE.
- Range: |V| <= RADIX^NDIG-1, so V fits in QW bits with no overflow.
- q_out keeps its last value after DONE→IDLE. It is meaningful only while out_valid=1.

Optional Feature:
- Macro: RR_OTF_DIGCHK_EN.
- Defined:
  - Extra output port err_out (1 bit, reset 0).
  - In CONV, a digit equal to -RADIX (encoding 1 followed by K zeros) sets a sticky error bit for the current word.
  - err_out equals that bit while out_valid=1. The bit clears on the next acceptance.
  - The conversion result is still produced using the standard update.
- Undefined: no err_out port and no checking logic.

Decomposition:
- Package rr_pkg: function clog2-based D/K derivation, digit-field extract helper, FSM state typedef (IDLE/CONV/DONE).
- One natural sub-module: rr_otf_step. It is combinational: Q, QM, d in; next Q, next QM out. The FSM module instantiates it once.

Test Plan:
All cases use WIDTH=4, RADIX=4 (NDIG=9, D=3, QW=19).
- All-zero digits, in_valid pulse -> out_valid 9 cycles after acceptance, q_out=0.
- d8=+1, others 0 -> q_out=65536.
- d8=+1, d7..d0=-3 -> q_out=1. Exercises QM path on every digit.
- All digits -3 -> q_out=-262143 (19'h40001). All digits +3 -> 262143.
- Hold out_ready=0 for 5 cycles in DONE -> q_out/out_valid stable, in_ready=0. Second word offered during this time is accepted only in the first IDLE cycle after the out handshake.
- Assert rst at cnt=4 of a conversion -> out_valid=0 and in_ready=1 immediately. The following word converts correctly.
- With RR_OTF_DIGCHK_EN: d3=3'b100 -> err_out=1 with the result. The next legal word gives err_out=0.
